// File: rtl/perceptron_trainer.sv
// Perceptron trainer: stores a labelled data set loaded over valid/ready and trains
// a saturating signed weight vector plus bias, one multiply-accumulate per cycle.
module perceptron_trainer #(
  parameter int N_DIM      = 2,
  parameter int N_SAMPLES  = 4,
  parameter int DW         = 8,
  parameter int WW         = 16,
  parameter int MAX_EPOCHS = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic signed [DW-1:0]              load_data,
  input  logic                              load_label,
  input  logic                              load_clr,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              converged,
  output logic [$clog2(MAX_EPOCHS+1)-1:0]   epochs,
  input  logic [$clog2(N_DIM+1)-1:0]        w_sel,
  output logic signed [WW-1:0]              w_out
);

  localparam int DEPTH = N_SAMPLES * N_DIM;
  localparam int MIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SIW   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int KW    = $clog2(N_DIM + 1);
  localparam int EW    = $clog2(MAX_EPOCHS + 1);
  localparam int PW    = DW + WW;
  localparam int AW    = DW + WW + KW + 1;
  localparam int XW    = ((DW > WW) ? DW : WW) + 2;

  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-WW+1){1'b1}}, {(WW-1){1'b0}}};

  // state   | meaning
  // S_IDLE  | loading samples, waiting for start
  // S_MAC   | N_DIM+1 cycles: acc = w.x + bias
  // S_DECIDE| compare prediction with label
  // S_UPDATE| N_DIM+1 cycles: w += / -= x, bias += / -= 1
  // S_DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DECIDE, S_UPDATE, S_DONE} state_t;

  state_t                r_state;
  logic                  r_full;
  logic [KW-1:0]         r_ld_f;
  logic [SIW-1:0]        r_ld_s;
  logic signed [DW-1:0]  r_mem [0:DEPTH-1];
  logic                  r_lab [0:N_SAMPLES-1];
  logic signed [WW-1:0]  r_w   [0:N_DIM];
  logic signed [AW-1:0]  r_acc;
  logic [KW-1:0]         r_k;
  logic [SIW-1:0]        r_sidx;
  logic                  r_err;
  logic [EW-1:0]         r_epochs;
  logic                  r_conv;
  logic                  r_busy;
  logic                  r_done;

  function automatic logic [MIW-1:0] f_addr(input logic [SIW-1:0] s, input logic [KW-1:0] f);
    return MIW'(s) * MIW'(N_DIM) + MIW'(f);
  endfunction

  function automatic logic signed [WW-1:0] f_sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX)      return WW'(SAT_MAX);
    else if (v < SAT_MIN) return WW'(SAT_MIN);
    else                  return v[WW-1:0];
  endfunction

  logic                  w_ld_hs;
  logic                  w_ld_last_f;
  logic                  w_ld_last_s;
  logic                  w_k_last;
  logic [KW-1:0]         w_kc;
  logic signed [DW-1:0]  w_x;
  logic signed [WW-1:0]  w_wk;
  logic signed [PW-1:0]  w_prod;
  logic signed [AW-1:0]  w_term;
  logic                  w_pos;
  logic                  w_lab;
  logic signed [XW-1:0]  w_upd_x;
  logic signed [XW-1:0]  w_upd_sum;
  logic signed [WW-1:0]  w_upd_sat;
  logic                  w_sample_end;
  logic                  w_last_sample;
  logic [EW-1:0]         w_ep_inc;

  assign load_ready  = (r_state == S_IDLE) && !r_full;
  assign w_ld_hs     = load_valid && load_ready && !load_clr;
  assign w_ld_last_f = (r_ld_f == KW'(N_DIM - 1));
  assign w_ld_last_s = (r_ld_s == SIW'(N_SAMPLES - 1));

  // Index N_DIM addresses the bias, whose implicit feature is 1.
  assign w_k_last  = (r_k == KW'(N_DIM));
  assign w_kc      = w_k_last ? '0 : r_k;
  assign w_x       = r_mem[f_addr(r_sidx, w_kc)];
  assign w_wk      = r_w[r_k];
  assign w_prod    = PW'(w_wk) * PW'(w_x);
  assign w_term    = w_k_last ? AW'(w_wk) : AW'(w_prod);
  assign w_pos     = !r_acc[AW-1] && (r_acc != '0);
  assign w_lab     = r_lab[r_sidx];
  assign w_upd_x   = w_k_last ? XW'(1) : XW'(w_x);
  assign w_upd_sum = w_lab ? (XW'(w_wk) + w_upd_x) : (XW'(w_wk) - w_upd_x);
  assign w_upd_sat = f_sat(w_upd_sum);

  assign w_sample_end  = ((r_state == S_DECIDE) && (w_pos == w_lab)) ||
                         ((r_state == S_UPDATE) && w_k_last);
  assign w_last_sample = (r_sidx == SIW'(N_SAMPLES - 1));
  assign w_ep_inc      = r_epochs + EW'(1);

  assign busy      = r_busy;
  assign done      = r_done;
  assign converged = r_conv;
  assign epochs    = r_epochs;
  assign w_out     = (w_sel <= KW'(N_DIM)) ? r_w[w_sel] : '0;

  always_ff @(posedge clk) begin
    if (w_ld_hs) begin
      r_mem[f_addr(r_ld_s, r_ld_f)] <= load_data;
      if (w_ld_last_f) r_lab[r_ld_s] <= load_label;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_full   <= 1'b0;
      r_ld_f   <= '0;
      r_ld_s   <= '0;
      for (int i = 0; i <= N_DIM; i++) r_w[i] <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_sidx   <= '0;
      r_err    <= 1'b0;
      r_epochs <= '0;
      r_conv   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_clr) begin
            r_full <= 1'b0;
            r_ld_f <= '0;
            r_ld_s <= '0;
          end else if (w_ld_hs) begin
            if (w_ld_last_f) begin
              r_ld_f <= '0;
              if (w_ld_last_s) begin
                r_full <= 1'b1;
                r_ld_s <= '0;
              end else begin
                r_ld_s <= r_ld_s + SIW'(1);
              end
            end else begin
              r_ld_f <= r_ld_f + KW'(1);
            end
          end
          if (start && r_full && !load_clr) begin
            for (int i = 0; i <= N_DIM; i++) r_w[i] <= '0;
            r_epochs <= '0;
            r_conv   <= 1'b0;
            r_err    <= 1'b0;
            r_sidx   <= '0;
            r_k      <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= (r_k == '0) ? w_term : (r_acc + w_term);
          if (w_k_last) begin
            r_k     <= '0;
            r_state <= S_DECIDE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DECIDE: begin
          if (w_pos != w_lab) begin
            r_err   <= 1'b1;
            r_k     <= '0;
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_w[r_k] <= w_upd_sat;
          if (!w_k_last) r_k <= r_k + KW'(1);
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Sample completion overrides the per-state next-state choice above.
      if (w_sample_end) begin
        r_k <= '0;
        if (w_last_sample) begin
          r_epochs <= w_ep_inc;
          r_sidx   <= '0;
          if (!r_err) begin
            r_conv  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_ep_inc == EW'(MAX_EPOCHS)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_err   <= 1'b0;
            r_state <= S_MAC;
          end
        end else begin
          r_sidx  <= r_sidx + SIW'(1);
          r_state <= S_MAC;
        end
      end
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: table of data sets (spec cases plus random ones)
// checked against a plain-arithmetic training model, plus reset/load/retrain sequences.
module tb_perceptron_trainer;
  localparam int ND = 2;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int WW = 16;
  localparam int ME = 15;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 load_valid = 1'b0;
  logic                 load_ready;
  logic signed [DW-1:0] load_data = '0;
  logic                 load_label = 1'b0;
  logic                 load_clr = 1'b0;
  logic                 start = 1'b0;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [3:0]           epochs;
  logic [1:0]           w_sel = '0;
  logic signed [WW-1:0] w_out;

  always #5 clk = ~clk;

  perceptron_trainer #(.N_DIM(ND), .N_SAMPLES(NS), .DW(DW), .WW(WW), .MAX_EPOCHS(ME)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_label(load_label), .load_clr(load_clr), .start(start),
    .busy(busy), .done(done), .converged(converged), .epochs(epochs),
    .w_sel(w_sel), .w_out(w_out)
  );

  typedef struct packed {
    logic [7:0][7:0]  x;
    logic [3:0]       lab;
    logic             conv;
    logic [3:0]       ep;
    logic [2:0][15:0] w;
    logic [15:0]      cyc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: the perceptron rule in integer arithmetic, plus the cycle budget
  // (N+2 per correct sample, 2N+3 per misclassified one, 1 for the done cycle).
  task automatic model(inout vec_t v);
    int w[3];
    int acc, ep, cyc, xi;
    bit err, fin, pred;
    w[0] = 0; w[1] = 0; w[2] = 0;
    ep = 0; cyc = 0; fin = 0; v.conv = 1'b0;
    while (!fin) begin
      err = 0;
      for (int s = 0; s < NS; s++) begin
        acc = w[ND];
        for (int k = 0; k < ND; k++) acc += w[k] * int'($signed(v.x[s*ND+k]));
        pred = (acc > 0);
        if (pred != v.lab[s]) begin
          err = 1;
          cyc += 2*ND + 3;
          for (int k = 0; k < ND; k++) begin
            xi = int'($signed(v.x[s*ND+k]));
            w[k] = sat(v.lab[s] ? w[k] + xi : w[k] - xi);
          end
          w[ND] = sat(v.lab[s] ? w[ND] + 1 : w[ND] - 1);
        end else begin
          cyc += ND + 2;
        end
      end
      ep++;
      if (!err) begin v.conv = 1'b1; fin = 1; end
      else if (ep == ME) fin = 1;
    end
    v.ep = 4'(ep);
    for (int k = 0; k <= ND; k++) v.w[k] = 16'(w[k]);
    v.cyc = 16'(cyc + 1);
  endtask

  task automatic load_set(input vec_t v);
    for (int i = 0; i < NS*ND; i++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("ready_before_word", int'(load_ready), 1);
      load_valid = 1'b1;
      load_data  = v.x[i];
      load_label = ((i % ND) == ND-1) ? v.lab[i/ND] : 1'($urandom);
      @(negedge clk);
      load_valid = 1'b0;
    end
    chk("ready_after_full", int'(load_ready), 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); load_clr = 1'b1;
    @(negedge clk); load_clr = 1'b0;
    chk("ready_after_clr", int'(load_ready), 1);
  endtask

  task automatic run_train(input vec_t v, input bit inject, input string tag);
    int cnt;
    bit seen;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0; seen = 0;
    for (int t = 0; t < 2000 && !seen; t++) begin
      if (busy) cnt++;
      if (done) begin
        seen = 1; start = 1'b0; load_valid = 1'b0;
        chk({tag, "_conv"}, int'(converged), int'(v.conv));
        chk({tag, "_epochs"}, int'(epochs), int'(v.ep));
        chk({tag, "_busy_cycles"}, cnt, int'(v.cyc));
        w_sel = 2'(ND); #1;
        chk({tag, "_bias_at_done"}, int'(w_out), int'($signed(v.w[ND])));
      end else begin
        if (inject) begin
          start      = ((t % 7) == 3);
          load_valid = ((t % 5) == 1);
          load_data  = 8'sh55;
        end
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    @(negedge clk);
    start = 1'b0; load_valid = 1'b0;
    chk({tag, "_done_pulse_len"}, int'(done), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    for (int k = 0; k <= ND; k++) begin
      w_sel = 2'(k); #1;
      chk($sformatf("%s_w%0d", tag, k), int'(w_out), int'($signed(v.w[k])));
    end
  endtask

  task automatic start_ignored(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk({tag, "_busy_stays_0"}, int'(busy), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t t_and;
    int a, b, c, acc;

    tbl[0].x   = {8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    tbl[0].lab = 4'b1000;
    model(tbl[0]);
    tbl[0].conv = 1'b1; tbl[0].ep = 4'd6;
    tbl[0].w[0] = 16'd2; tbl[0].w[1] = 16'd1; tbl[0].w[2] = 16'hFFFE;
    tbl[1].x   = tbl[0].x;
    tbl[1].lab = 4'b0110;
    model(tbl[1]);
    tbl[1].conv = 1'b0; tbl[1].ep = 4'd15;
    for (int i = 2; i < 6; i++) begin
      for (int j = 0; j < NS*ND; j++) tbl[i].x[j] = 8'($urandom);
      a = int'($urandom_range(0, 6)) - 3;
      b = int'($urandom_range(0, 6)) - 3;
      c = int'($urandom_range(0, 200)) - 100;
      for (int s = 0; s < NS; s++) begin
        acc = a * int'($signed(tbl[i].x[s*ND])) + b * int'($signed(tbl[i].x[s*ND+1])) + c;
        tbl[i].lab[s] = (i < 4) ? (acc > 0) : 1'($urandom);
      end
      model(tbl[i]);
    end
    t_and = tbl[0];

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_load_ready", int'(load_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_converged", int'(converged), 0);
    chk("rst_epochs", int'(epochs), 0);
    for (int k = 0; k < 4; k++) begin
      w_sel = 2'(k); #1;
      chk($sformatf("rst_w%0d", k), int'(w_out), 0);
    end
    start_ignored("empty_mem");

    for (int i = 0; i < 6; i++) begin
      load_set(tbl[i]);
      run_train(tbl[i], 1'b0, $sformatf("vec%0d", i));
      pulse_clr();
    end

    load_set(t_and);
    @(negedge clk); load_valid = 1'b1; load_data = 8'sh7f;
    @(negedge clk); load_valid = 1'b0;
    chk("ninth_word_ready", int'(load_ready), 0);
    run_train(t_and, 1'b1, "and_inject");
    w_sel = 2'd3; #1;
    chk("w_sel_out_of_range", int'(w_out), 0);
    run_train(t_and, 1'b0, "and_retrain");

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (25) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(load_ready), 1);
    chk("midrst_epochs", int'(epochs), 0);
    chk("midrst_converged", int'(converged), 0);
    chk("midrst_done", int'(done), 0);
    for (int k = 0; k <= ND; k++) begin
      w_sel = 2'(k); #1;
      chk($sformatf("midrst_w%0d", k), int'(w_out), 0);
    end
    start_ignored("midrst_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Parametrised on-chip perceptron trainer: holds a small labelled data set loaded over a valid/ready stream and trains a signed weight vector plus bias with the classic perceptron rule, one multiply per cycle, epoch after epoch. Training stops on convergence (one error-free epoch) or after `MAX_EPOCHS`. It is the generalised successor of the fixed 2-input, 3-sample perceptron core: any dimension, sample count and width, with real sample loading, bias, saturation and status reporting. Weights are read back through an indexed port for display or downstream inference.

## Interface
- `N_DIM`, 2: features per sample (≥1).
- `N_SAMPLES`, 4: samples in the data set (≥1).
- `DW`, 8: signed feature width.
- `WW`, 16: signed weight/bias width.
- `MAX_EPOCHS`, 15: epoch limit (≥1).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  feature word valid.
- `load_ready`  out  1  block accepts a feature word.
- `load_data`  in  DW  signed feature value.
- `load_label`  in  1  class label, sampled with the last feature of each sample.
- `load_clr`  in  1  in IDLE: rewind load pointer, mark memory empty.
- `start`  in  1  begin training (single-cycle pulse).
- `busy`  out  1  training in progress.
- `done`  out  1  one-cycle pulse when training ends.
- `converged`  out  1  last run ended error-free; held until next accepted start.
- `epochs`  out  clog2(MAX_EPOCHS+1)  epochs completed in current/last run.
- `w_sel`  in  clog2(N_DIM+1)  weight index; `N_DIM` selects bias.
- `w_out`  out  WW  combinational read of the selected weight; out-of-range index reads 0.

## Operation
- States: IDLE, MAC, DECIDE, UPDATE, DONE.
- IDLE: `load_ready` = 1 while memory not full. Each handshake (`load_valid`&`load_ready`) writes `load_data` at the pointer; order: sample 0 features 0..N_DIM-1, sample 1, … The label is stored on the handshake of feature N_DIM-1. After N_SAMPLES·N_DIM words memory is full and `load_ready` = 0. `load_clr` has priority over a same-cycle handshake.
- `start` accepted only in IDLE with memory full: clears all weights and bias to 0, `epochs` and `converged` to 0, epoch error flag to 0, sample index to 0; enters MAC. Otherwise ignored.
- MAC: N_DIM+1 cycles, accumulator cleared at entry; acc += w[k]·x[k] for k = 0..N_DIM-1, then acc += bias (implicit x = 1). Accumulator width DW+WW+clog2(N_DIM+1)+1 bits, no overflow.
- DECIDE: 1 cycle. pred = (acc > 0), strictly. If pred == label: go to next sample. Else set epoch error flag, go to UPDATE.
- UPDATE: N_DIM+1 cycles; label 1: w[k] += x[k], bias += 1; label 0: w[k] −= x[k], bias −= 1. Each result saturates to signed WW range.
- After last sample of an epoch: `epochs` += 1; error flag 0 → DONE with `converged` = 1; else if `epochs` == MAX_EPOCHS → DONE with `converged` = 0; else clear error flag, sample index 0, MAC.
- DONE: 1 cycle, `done` = 1, returns to IDLE. Memory stays full; weights held. New `start` retrains the same data.
- `load_valid`, `load_clr`, `start` outside IDLE ignored. `w_sel` usable any time; reads live weights during training.

## Timing
- Reset: state IDLE, memory empty, pointer 0, weights/bias 0, `load_ready` = 1, `busy` = 0, `done` = 0, `converged` = 0, `epochs` = 0. Reset mid-training aborts immediately to this state.
- `busy` = 1 from the cycle after an accepted `start` through the DONE cycle inclusive.
- Per sample: N_DIM+2 cycles if correct, 2·N_DIM+3 if misclassified.
- `done` and final `converged`/`epochs` visible in the same cycle; `w_out` final from that cycle.

## Test plan
- Reset values: after reset all outputs as listed; `start` with empty memory -> `busy` stays 0.
- Load handshake (N_DIM=2, N_SAMPLES=4): 8 words with `load_valid` gaps -> `load_ready` falls after the 8th handshake; 9th word not accepted; `load_clr` -> `load_ready` = 1.
- AND set (0,0,0),(0,1,0),(1,0,0),(1,1,1) -> `done` pulse, `converged` = 1, `epochs` = 6, w = (2, 1), bias = −2.
- XOR set (0,0,0),(0,1,1),(1,0,1),(1,1,0), MAX_EPOCHS=15 -> `converged` = 0, `epochs` = 15.
- `start` and `load_valid` asserted during training -> no effect on result; retrain via second `start` -> identical AND result.
- `rst_n` low for 1 cycle mid-epoch -> next cycle IDLE, weights 0, memory empty, `busy` = 0.
